// File: rtl/seq_div16_ctrl_if.sv
// Purpose: adder request/response bus between the divider (master) and a shared 16-bit add/sub unit (slave).
// Ports: add_en/add_sub/add_a/add_b driven by the master; add_result/add_cout/add_ready returned by the slave.
// Protocol: operands are stable while add_en=1; add_ready marks the result valid and falls after add_en drops.
interface seq_div16_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             add_en;
    logic             add_sub;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_result;
    logic             add_cout;
    logic             add_ready;

    modport master (
        output add_en, add_sub, add_a, add_b,
        input  add_result, add_cout, add_ready
    );

    modport slave (
        input  add_en, add_sub, add_a, add_b,
        output add_result, add_cout, add_ready
    );
endinterface

// File: rtl/seq_div16_ctrl.sv
// Purpose: 16-bit unsigned restoring divider that borrows an external adder for every quotient bit.
// Latency: 16*(SHIFT + REQ wait + RELEASE) + 2 cycles start->done; divide-by-zero completes straight away.
// Backpressure: waits on add_ready in REQ (aborts with err after MAX_WAIT+1 cycles); start ignored unless IDLE.
// Ports: clk, rst (sync, active-high); start_i/dividend_i/divisor_i request; busy_o/done_o/quotient_o/
//        remainder_o/div_zero_o/err_o status and results; add_if is the master side of the adder bus.
module seq_div16_ctrl #(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o,
    output logic             err_o,
    seq_div16_ctrl_if.master add_if
);
    localparam int CW = $clog2(WIDTH);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_REQ,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             msb_q, msb_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            msb_q       <= 1'b0;
            dvs_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            msb_q       <= msb_d;
            dvs_q       <= dvs_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        msb_d       = msb_q;
        dvs_d       = dvs_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    div_zero_d = 1'b0;
                    err_d      = 1'b0;
                    dvs_d      = divisor_i;
                    cnt_d      = CW'(WIDTH - 1);
                    if (divisor_i == '0) begin
                        // Divide-by-zero never touches the adder.
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        div_zero_d  = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d   = '0;
                        msb_d   = 1'b0;
                        quo_d   = dividend_i;
                        state_d = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                // {msb, R, Q} <= {R, Q, 0}; msb keeps the 17th bit the adder cannot see.
                msb_d   = rem_q[WIDTH-1];
                rem_d   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d   = {quo_q[WIDTH-2:0], 1'b0};
                add_a_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                add_b_d = dvs_q;
                wait_d  = '0;
                state_d = S_REQ;
            end

            S_REQ: begin
                if (add_if.add_ready) begin
                    // A set msb means the shifted remainder exceeds any 16-bit divisor, so the
                    // subtract always commits; the wrapped adder result is then exact mod 2^16.
                    if (msb_q || add_if.add_cout) begin
                        rem_d = add_if.add_result;
                        quo_d = {quo_q[WIDTH-1:1], 1'b1};
                    end
                    state_d = S_RELEASE;
                end else if (wait_q == WW'(MAX_WAIT)) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_RELEASE: begin
                // Hold until the adder drops ready so the next REQ cannot see a stale one.
                if (!add_if.add_ready) begin
                    if (cnt_q == '0) begin
                        quotient_d  = quo_q;
                        remainder_d = rem_q;
                        state_d     = S_DONE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_SHIFT;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q == S_SHIFT) || (state_q == S_REQ) || (state_q == S_RELEASE);
    assign done_o      = (state_q == S_DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign div_zero_o  = div_zero_q;
    assign err_o       = err_q;

    assign add_if.add_en  = (state_q == S_REQ);
    assign add_if.add_sub = (state_q == S_REQ);
    assign add_if.add_a   = add_a_q;
    assign add_if.add_b   = add_b_q;
endmodule

// File: tb/tb_seq_div16_ctrl.sv
// Purpose: self-checking bench for seq_div16_ctrl with a registered adder model of configurable latency.
// Latency: adder ready L cycles after add_en rises (or never, in stall mode); cleared the cycle after add_en falls.
// Backpressure: the adder model is the only source of stall; every wait on the DUT is cycle-bounded.
module tb_seq_div16_ctrl;
    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] dividend_i;
    logic [15:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] quotient_o;
    logic [15:0] remainder_o;
    logic        div_zero_o;
    logic        err_o;

    seq_div16_ctrl_if #(.WIDTH(16)) aif ();

    seq_div16_ctrl #(.WIDTH(16), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div_zero_o  (div_zero_o),
        .err_o       (err_o),
        .add_if      (aif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Registered adder: A + ~B + 1 with carry out; ready after lat_cfg cycles of add_en.
    int lat_cfg   = 2;
    bit stall_cfg = 1'b0;
    int lat_cnt;

    always @(posedge clk) begin
        if (rst || !aif.add_en) begin
            aif.add_ready <= 1'b0;
            lat_cnt       <= 0;
        end else begin
            lat_cnt       <= lat_cnt + 1;
            aif.add_ready <= !stall_cfg && (lat_cnt + 1 >= lat_cfg);
            {aif.add_cout, aif.add_result} <= {1'b0, aif.add_a} + {1'b0, ~aif.add_b} + 17'd1;
        end
    end

    // Reference for the transaction in flight, from plain integer division.
    logic [15:0] exp_q, exp_r, exp_b;
    logic        exp_dz, exp_err;

    // Single compare process: results whenever done pulses, adder operands whenever a request is up.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_o) begin
                chk("quotient", 32'(quotient_o), 32'(exp_q));
                chk("remainder", 32'(remainder_o), 32'(exp_r));
                chk("div_zero", 32'(div_zero_o), 32'(exp_dz));
                chk("err", 32'(err_o), 32'(exp_err));
                chk("busy_at_done", 32'(busy_o), 32'd0);
            end
            if (aif.add_en) begin
                chk("add_sub", 32'(aif.add_sub), 32'd1);
                chk("add_b", 32'(aif.add_b), 32'(exp_b));
            end
        end
    end

    task automatic set_model(input logic [15:0] a, input logic [15:0] b, input bit stall);
        exp_b = b;
        if (b == 16'd0) begin
            exp_q = 16'hFFFF; exp_r = a; exp_dz = 1'b1; exp_err = 1'b0;
        end else if (stall) begin
            exp_q = 16'd0; exp_r = 16'd0; exp_dz = 1'b0; exp_err = 1'b1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_err = 1'b0;
        end
    endtask

    // Issues one operation and follows it to done. cycles counts samples after the accepting edge
    // (1 = done visible right after acceptance). poke fires a stray start mid-operation.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int lat, input bit stall,
                          input bit poke, output int cycles, output int en_edges, output int req_cycles,
                          output bit got_done);
        bit prev_en;
        prev_en    = 1'b0;
        en_edges   = 0;
        req_cycles = 0;
        got_done   = 1'b0;
        @(negedge clk);
        lat_cfg    = lat;
        stall_cfg  = stall;
        set_model(a, b, stall);
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk);
        start_i = 1'b0;
        cycles  = 1;
        if (b != 16'd0) chk("busy_after_start", 32'(busy_o), 32'd1);
        while (cycles < 1000) begin
            if (done_o) begin
                got_done = 1'b1;
                break;
            end
            if (aif.add_en && !prev_en) en_edges++;
            if (aif.add_en) req_cycles++;
            prev_en = aif.add_en;
            if (poke && cycles == 10) begin
                start_i    = 1'b1;
                dividend_i = ~a;
                divisor_i  = b + 16'd3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start_i = 1'b0;
        chk("done_seen", 32'(got_done), 32'd1);
    endtask

    int cyc, edges, reqc;
    bit gd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        dividend_i = 16'd0;
        divisor_i  = 16'd0;
        set_model(16'd0, 16'd1, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_quotient", 32'(quotient_o), 32'd0);
        chk("rst_remainder", 32'(remainder_o), 32'd0);
        chk("rst_div_zero", 32'(div_zero_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_add_en", 32'(aif.add_en), 32'd0);
        chk("rst_add_a", 32'(aif.add_a), 32'd0);
        chk("rst_add_b", 32'(aif.add_b), 32'd0);
        rst = 1'b0;

        // 100 / 7, with a stray start mid-operation that must be ignored.
        run_op(16'd100, 16'd7, 2, 1'b0, 1'b1, cyc, edges, reqc, gd);
        chk("d100_7_q", 32'(quotient_o), 32'd14);
        chk("d100_7_r", 32'(remainder_o), 32'd2);
        chk("d100_7_dz", 32'(div_zero_o), 32'd0);
        chk("d100_7_err", 32'(err_o), 32'd0);
        chk("d100_7_en_edges", 32'(edges), 32'd16);
        repeat (3) @(negedge clk);
        chk("held_q", 32'(quotient_o), 32'd14);
        chk("held_r", 32'(remainder_o), 32'd2);
        chk("held_busy", 32'(busy_o), 32'd0);

        run_op(16'd65535, 16'd1, 2, 1'b0, 1'b0, cyc, edges, reqc, gd);
        chk("d65535_1_q", 32'(quotient_o), 32'd65535);
        chk("d65535_1_r", 32'(remainder_o), 32'd0);

        run_op(16'd40000, 16'd40001, 2, 1'b0, 1'b0, cyc, edges, reqc, gd);
        chk("d40000_40001_q", 32'(quotient_o), 32'd0);
        chk("d40000_40001_r", 32'(remainder_o), 32'd40000);

        run_op(16'd65535, 16'd32769, 2, 1'b0, 1'b0, cyc, edges, reqc, gd);
        chk("d65535_32769_q", 32'(quotient_o), 32'd1);
        chk("d65535_32769_r", 32'(remainder_o), 32'd32766);

        // Divide by zero: done in the cycle straight after the accepting edge, no adder traffic.
        run_op(16'd5, 16'd0, 2, 1'b0, 1'b0, cyc, edges, reqc, gd);
        chk("d5_0_latency", 32'(cyc), 32'd1);
        chk("d5_0_q", 32'(quotient_o), 32'hFFFF);
        chk("d5_0_r", 32'(remainder_o), 32'd5);
        chk("d5_0_dz", 32'(div_zero_o), 32'd1);
        chk("d5_0_en_edges", 32'(reqc), 32'd0);

        // Adder never answers: abort after MAX_WAIT+1 request cycles.
        run_op(16'd1234, 16'd5, 2, 1'b1, 1'b0, cyc, edges, reqc, gd);
        chk("stall_err", 32'(err_o), 32'd1);
        chk("stall_q", 32'(quotient_o), 32'd0);
        chk("stall_req_cycles", 32'(reqc), 32'd16);
        chk("stall_en_edges", 32'(edges), 32'd1);
        chk("stall_dz", 32'(div_zero_o), 32'd0);

        // Reset in the middle of 1000 / 10.
        @(negedge clk);
        stall_cfg  = 1'b0;
        lat_cfg    = 2;
        set_model(16'd1000, 16'd10, 1'b0);
        start_i    = 1'b1;
        dividend_i = 16'd1000;
        divisor_i  = 16'd10;
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_add_en", 32'(aif.add_en), 32'd0);
        chk("midrst_add_a", 32'(aif.add_a), 32'd0);
        chk("midrst_add_b", 32'(aif.add_b), 32'd0);
        chk("midrst_quotient", 32'(quotient_o), 32'd0);
        chk("midrst_remainder", 32'(remainder_o), 32'd0);
        chk("midrst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done_o), 32'd0);
        end

        run_op(16'd1000, 16'd10, 2, 1'b0, 1'b0, cyc, edges, reqc, gd);
        chk("d1000_10_q", 32'(quotient_o), 32'd100);
        chk("d1000_10_r", 32'(remainder_o), 32'd0);

        // Random operands and adder latency; compare process checks every result.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            int          mode;
            a    = 16'($urandom);
            mode = $urandom_range(0, 15);
            if (mode == 0)      b = 16'd0;
            else if (mode < 5)  b = 16'($urandom_range(1, 15));
            else if (mode < 8)  b = 16'($urandom_range(32768, 65535));
            else                b = 16'($urandom);
            run_op(a, b, $urandom_range(1, 5), 1'b0, ($urandom_range(0, 3) == 0), cyc, edges, reqc, gd);
            if (b != 16'd0) chk("rand_en_edges", 32'(edges), 32'd16);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
